chirp_frame_scheduler: RTL and testbench

Sequences the chirp processing core over a multi-chirp, multi-frame capture. After one software start it latches the configuration and issues one core start pulse per chirp, together with per-chirp AXI read and write base addresses. Before each next chirp it waits for the core end indication and for the write path to drain. It sits between the register file and the chirp processing core, and reports progress, completion and timeout errors.

---
 rtl/chirp_frame_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_chirp_frame_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chirp_frame_scheduler.sv
// Chirp/frame sequencer: after one software start it walks the core through
// chirp_num chirps per frame for frame_num frames, issuing one start pulse and
// per-chirp AXI base addresses per chirp, with a watchdog and abort path.
module chirp_frame_scheduler #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CHP_W  = 10,
  parameter int unsigned FRM_W  = 4,
  parameter int unsigned TMO_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cfg_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CHP_W-1:0]  cfg_chirp_num,
  input  logic [FRM_W-1:0]  cfg_frame_num,
  input  logic [TMO_W-1:0]  cfg_timeout,
  input  logic              i_core_end,
  input  logic              i_wr_idle,
  output logic              o_core_start,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [CHP_W-1:0]  o_chirp_idx,
  output logic [FRM_W-1:0]  o_frame_idx,
  output logic              o_chirp_last,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_END, S_DRAIN, S_NEXT, S_FIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_base, r_wr_base, r_stride;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
  logic [CHP_W-1:0]  r_chirp_num, r_chirp_idx;
  logic [FRM_W-1:0]  r_frame_num, r_frame_idx;
  logic [TMO_W-1:0]  r_timeout, r_wdog;
  logic              r_core_start, r_frame_done, r_busy, r_done, r_err_timeout;
  logic              w_chirp_last, w_frame_last, w_wdog_expired;

  // Reset values of the latched counts (0) never match idx==num-1, so the
  // last-chirp flag is naturally low out of reset.
  assign w_chirp_last   = (r_chirp_idx == r_chirp_num - CHP_W'(1));
  assign w_frame_last   = (r_frame_idx == r_frame_num - FRM_W'(1));
  assign w_wdog_expired = (r_timeout != '0) && (r_wdog == r_timeout);

  assign o_core_start  = r_core_start;
  assign o_rd_addr     = r_rd_addr;
  assign o_wr_addr     = r_wr_addr;
  assign o_chirp_idx   = r_chirp_idx;
  assign o_frame_idx   = r_frame_idx;
  assign o_chirp_last  = w_chirp_last;
  assign o_frame_done  = r_frame_done;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err_timeout = r_err_timeout;

  // Sequencer FSM; pulses are registered so they coincide with their state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rd_base     <= '0;
      r_wr_base     <= '0;
      r_stride      <= '0;
      r_rd_addr     <= '0;
      r_wr_addr     <= '0;
      r_chirp_num   <= '0;
      r_chirp_idx   <= '0;
      r_frame_num   <= '0;
      r_frame_idx   <= '0;
      r_timeout     <= '0;
      r_wdog        <= '0;
      r_core_start  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      r_frame_done <= 1'b0;
      r_done       <= 1'b0;
      if (i_abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_wdog  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_cfg_start) begin
              r_state       <= S_LOAD;
              r_busy        <= 1'b1;
              r_err_timeout <= 1'b0;
            end
          end
          S_LOAD: begin
            r_rd_base   <= cfg_rd_base;
            r_wr_base   <= cfg_wr_base;
            r_stride    <= cfg_stride;
            r_chirp_num <= cfg_chirp_num;
            r_frame_num <= cfg_frame_num;
            r_timeout   <= cfg_timeout;
            r_rd_addr   <= cfg_rd_base;
            r_wr_addr   <= cfg_wr_base;
            r_chirp_idx <= '0;
            r_frame_idx <= '0;
            if ((cfg_chirp_num == '0) || (cfg_frame_num == '0)) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state      <= S_START;
              r_core_start <= 1'b1;
            end
          end
          S_START: begin
            r_state <= S_WAIT_END;
            r_wdog  <= '0;
          end
          S_WAIT_END: begin
            if (i_core_end) begin
              r_state <= S_DRAIN;
              r_wdog  <= '0;
            end else if (w_wdog_expired) begin
              r_state       <= S_FIN;
              r_done        <= 1'b1;
              r_err_timeout <= 1'b1;
              r_wdog        <= '0;
            end else begin
              r_wdog <= r_wdog + TMO_W'(1);
            end
          end
          S_DRAIN: begin
            if (i_wr_idle) begin
              r_state      <= S_NEXT;
              r_frame_done <= w_chirp_last;
              r_wdog       <= '0;
            end else if (w_wdog_expired) begin
              r_state       <= S_FIN;
              r_done        <= 1'b1;
              r_err_timeout <= 1'b1;
              r_wdog        <= '0;
            end else begin
              r_wdog <= r_wdog + TMO_W'(1);
            end
          end
          S_NEXT: begin
            if (!w_chirp_last) begin
              r_chirp_idx  <= r_chirp_idx + CHP_W'(1);
              r_rd_addr    <= r_rd_addr + r_stride;
              r_wr_addr    <= r_wr_addr + r_stride;
              r_state      <= S_START;
              r_core_start <= 1'b1;
            end else if (!w_frame_last) begin
              r_chirp_idx  <= '0;
              r_frame_idx  <= r_frame_idx + FRM_W'(1);
              r_rd_addr    <= r_rd_base;
              r_wr_addr    <= r_wr_base;
              r_state      <= S_START;
              r_core_start <= 1'b1;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chirp_frame_scheduler.sv
// Directed bench for chirp_frame_scheduler: sequencing, addresses, latency,
// watchdog boundaries, abort, ignored restart and asynchronous reset.
module tb_chirp_frame_scheduler;

  logic        clk;
  logic        rst_n;
  logic        i_cfg_start;
  logic        i_abort;
  logic [31:0] cfg_rd_base, cfg_wr_base, cfg_stride;
  logic [9:0]  cfg_chirp_num;
  logic [3:0]  cfg_frame_num;
  logic [23:0] cfg_timeout;
  logic        i_core_end;
  logic        i_wr_idle;
  logic        o_core_start;
  logic [31:0] o_rd_addr, o_wr_addr;
  logic [9:0]  o_chirp_idx;
  logic [3:0]  o_frame_idx;
  logic        o_chirp_last, o_frame_done, o_busy, o_done, o_err_timeout;

  logic        core_end_auto;
  logic        auto_en;
  int          auto_delay;
  int          end_cd;

  int          cyc;
  int          n_checks;
  int          n_fail;

  logic [31:0] st_cyc[$];
  logic [31:0] st_rd[$];
  logic [31:0] st_wr[$];
  logic [9:0]  st_ch[$];
  logic [3:0]  st_fr[$];
  logic        st_last[$];
  int          fd_cnt, done_cnt, busy_cnt, done_cyc;
  logic        done_err;

  assign i_core_end = core_end_auto;

  chirp_frame_scheduler #(
    .ADDR_W(32), .CHP_W(10), .FRM_W(4), .TMO_W(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_start(i_cfg_start), .i_abort(i_abort),
    .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base), .cfg_stride(cfg_stride),
    .cfg_chirp_num(cfg_chirp_num), .cfg_frame_num(cfg_frame_num),
    .cfg_timeout(cfg_timeout), .i_core_end(i_core_end), .i_wr_idle(i_wr_idle),
    .o_core_start(o_core_start), .o_rd_addr(o_rd_addr), .o_wr_addr(o_wr_addr),
    .o_chirp_idx(o_chirp_idx), .o_frame_idx(o_frame_idx),
    .o_chirp_last(o_chirp_last), .o_frame_done(o_frame_done), .o_busy(o_busy),
    .o_done(o_done), .o_err_timeout(o_err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: pulses core_end auto_delay cycles after each observed start.
  always @(negedge clk) begin
    core_end_auto = 1'b0;
    if (end_cd != 0) begin
      end_cd = end_cd - 1;
      if (end_cd == 0) core_end_auto = 1'b1;
    end
    if (auto_en && o_core_start && rst_n) end_cd = auto_delay;
  end

  // Event log sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_core_start) begin
        st_cyc.push_back(cyc);
        st_rd.push_back(o_rd_addr);
        st_wr.push_back(o_wr_addr);
        st_ch.push_back(o_chirp_idx);
        st_fr.push_back(o_frame_idx);
        st_last.push_back(o_chirp_last);
      end
      if (o_frame_done) fd_cnt = fd_cnt + 1;
      if (o_done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
        done_err = o_err_timeout;
      end
      if (o_busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    st_cyc.delete(); st_rd.delete(); st_wr.delete();
    st_ch.delete();  st_fr.delete(); st_last.delete();
    fd_cnt = 0; done_cnt = 0; busy_cnt = 0; done_cyc = 0; done_err = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] rd, input logic [31:0] wr, input logic [31:0] str,
                         input logic [9:0] cn, input logic [3:0] fn, input logic [23:0] tmo);
    cfg_rd_base = rd; cfg_wr_base = wr; cfg_stride = str;
    cfg_chirp_num = cn; cfg_frame_num = fn; cfg_timeout = tmo;
  endtask

  // Returns at #1 into the cycle after the pulse; t0 is the pulse cycle.
  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    i_cfg_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    i_cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int   prev;
    logic seen;
    prev = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk); #2;
      if (done_cnt != prev) seen = 1'b1;
    end
    chk(tag, seen, 1'b1);
  endtask

  task automatic wait_starts(input string tag, input int n, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk); #2;
      if (st_cyc.size() >= n) seen = 1'b1;
    end
    chk(tag, seen, 1'b1);
  endtask

  int t0, r, s;

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; end_cd = 0; core_end_auto = 1'b0;
    auto_en = 1'b0; auto_delay = 20;
    rst_n = 1'b0; i_cfg_start = 1'b0; i_abort = 1'b0; i_wr_idle = 1'b1;
    set_cfg(32'h0, 32'h0, 32'h0, 10'd0, 4'd0, 24'd0);
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", {o_rd_addr, o_wr_addr}, 64'h0);
    chk("rst_flags", {o_core_start, o_chirp_last, o_frame_done, o_busy, o_done, o_err_timeout,
                      o_chirp_idx, o_frame_idx}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: 3 chirps x 2 frames, core end 20 cycles after each start.
    clear_logs();
    auto_en = 1'b1; auto_delay = 20;
    set_cfg(32'h1000_0000, 32'h2000_0000, 32'h4000, 10'd3, 4'd2, 24'd0);
    pulse_start(t0);
    wait_done("t1_done_seen", 400);
    chk("t1_starts", st_cyc.size(), 6);
    if (st_cyc.size() == 6) begin
      chk("t1_first_lat", st_cyc[0], t0 + 2);
      chk("t1_chirp_gap", st_cyc[1], st_cyc[0] + 23);
      chk("t1_frame_gap", st_cyc[3], st_cyc[2] + 23);
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t1_rd%0d", i), st_rd[i], 32'h1000_0000 + 32'h4000 * (i % 3));
        chk($sformatf("t1_wr%0d", i), st_wr[i], 32'h2000_0000 + 32'h4000 * (i % 3));
        chk($sformatf("t1_idx%0d", i), {st_fr[i], st_ch[i]}, {4'(i / 3), 10'(i % 3)});
        chk($sformatf("t1_last%0d", i), st_last[i], (i % 3) == 2);
      end
      chk("t1_done_cyc", done_cyc, st_cyc[5] + 23);
    end
    chk("t1_frame_done", fd_cnt, 2);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_err", done_err, 1'b0);
    repeat (3) @(posedge clk);

    // 2: zero chirps -> LOAD then FIN, no core start.
    clear_logs();
    set_cfg(32'h1000_0000, 32'h2000_0000, 32'h4000, 10'd0, 4'd5, 24'd0);
    pulse_start(t0);
    wait_done("t2_done_seen", 20);
    repeat (3) @(posedge clk);
    chk("t2_done_cyc", done_cyc, t0 + 2);
    chk("t2_starts", st_cyc.size(), 0);
    chk("t2_busy_cycles", busy_cnt, 2);

    // 3: watchdog 100, core never ends.
    clear_logs();
    auto_en = 1'b0;
    set_cfg(32'h1000_0000, 32'h2000_0000, 32'h4000, 10'd3, 4'd1, 24'd100);
    pulse_start(t0);
    wait_done("t3_done_seen", 300);
    chk("t3_starts", st_cyc.size(), 1);
    if (st_cyc.size() == 1) chk("t3_done_cyc", done_cyc, st_cyc[0] + 102);
    chk("t3_err_at_done", done_err, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t3_err_sticky", o_err_timeout, 1'b1);
    set_cfg(32'h0, 32'h0, 32'h0, 10'd0, 4'd1, 24'd0);
    pulse_start(t0);
    @(negedge clk);
    chk("t3_err_cleared", o_err_timeout, 1'b0);
    wait_done("t3b_done_seen", 20);
    repeat (3) @(posedge clk);

    // 4a: write path stays busy for 50 cycles after core end.
    clear_logs();
    auto_en = 1'b1; auto_delay = 5;
    i_wr_idle = 1'b0;
    set_cfg(32'h1000_0000, 32'h2000_0000, 32'h100, 10'd2, 4'd1, 24'd0);
    pulse_start(t0);
    wait_starts("t4_first_start", 1, 20);
    repeat (55) @(posedge clk);
    chk("t4_held_starts", st_cyc.size(), 1);
    #1;
    i_wr_idle = 1'b1;
    r = cyc;
    wait_starts("t4_second_start", 2, 20);
    // wr_idle first high in cycle r: DRAIN exits at its end, NEXT r+1, START r+2.
    if (st_cyc.size() >= 2) chk("t4_restart_cyc", st_cyc[1], r + 2);
    wait_done("t4_done_seen", 50);
    repeat (3) @(posedge clk);

    // 4b: core end in the very cycle the watchdog expires -> no error.
    clear_logs();
    auto_delay = 11;
    set_cfg(32'h1000_0000, 32'h2000_0000, 32'h100, 10'd1, 4'd1, 24'd10);
    pulse_start(t0);
    wait_done("t4b_done_seen", 50);
    if (st_cyc.size() == 1) chk("t4b_done_cyc", done_cyc, st_cyc[0] + 14);
    chk("t4b_err", done_err, 1'b0);
    repeat (3) @(posedge clk);

    // 4c: core end one cycle late -> watchdog wins.
    clear_logs();
    auto_delay = 12;
    pulse_start(t0);
    wait_done("t4c_done_seen", 50);
    if (st_cyc.size() == 1) chk("t4c_done_cyc", done_cyc, st_cyc[0] + 12);
    chk("t4c_err", done_err, 1'b1);
    repeat (5) @(posedge clk);

    // 5: ignored restart mid-run, then abort in WAIT_END of chirp 1.
    clear_logs();
    auto_delay = 20;
    set_cfg(32'h1000_0000, 32'h2000_0000, 32'h4000, 10'd3, 4'd1, 24'd0);
    pulse_start(t0);
    wait_starts("t5_first_start", 1, 20);
    repeat (3) @(posedge clk);
    pulse_start(r);
    wait_starts("t5_second_start", 2, 40);
    if (st_cyc.size() >= 2) begin
      chk("t5_restart_ignored_cyc", st_cyc[1], st_cyc[0] + 23);
      chk("t5_restart_ignored_idx", st_ch[1], 10'd1);
    end
    repeat (3) @(posedge clk); #1;
    i_abort = 1'b1;
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    chk("t5_abort_busy", o_busy, 1'b0);
    repeat (30) @(posedge clk);
    chk("t5_abort_no_done", done_cnt, 0);
    chk("t5_abort_starts", st_cyc.size(), 2);
    chk("t5_abort_err", o_err_timeout, 1'b0);

    // 6: read address wraps past 2^32; async reset mid-run.
    clear_logs();
    auto_delay = 5;
    set_cfg(32'hFFFF_C000, 32'h3000_0000, 32'h4000, 10'd2, 4'd1, 24'd0);
    pulse_start(t0);
    wait_starts("t6_second_start", 2, 40);
    if (st_cyc.size() >= 2) begin
      chk("t6_rd0", st_rd[0], 32'hFFFF_C000);
      chk("t6_rd_wrap", st_rd[1], 32'h0000_0000);
      chk("t6_wr1", st_wr[1], 32'h3000_4000);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_addr", {o_rd_addr, o_wr_addr}, 64'h0);
    chk("t6_rst_flags", {o_core_start, o_chirp_last, o_frame_done, o_busy, o_done, o_err_timeout,
                         o_chirp_idx, o_frame_idx}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
